// File: rtl/seg_scan_pkg.sv
// Shared definitions for the seven-segment scan decoder: segment codes, FSM states, digit count.
// Pure declarations; no logic.
package seg_scan_pkg;

  localparam int NUM_DIGITS = 8;

  // Active-low cathode patterns, bit 0 = segment a ... bit 6 = segment g
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef enum logic [1:0] {
    WAIT   = 2'd0,
    SETTLE = 2'd1,
    HOLD   = 2'd2
  } state_t;

endpackage

// File: rtl/seg_scan_decoder_seg7.sv
// Combinational cathode-pattern to BCD decode; zero latency, no flow control.
// With SEG_BLANK_AS_ZERO_EN defined, an all-off pattern decodes as a legal 0.
module seg7_to_bcd
  import seg_scan_pkg::*;
(
  input  logic [6:0] cat,
  output logic [3:0] digit,
  output logic       legal
);

  always_comb begin
    digit = 4'd0;
    legal = 1'b1;
    case (cat)
      SEG_0:     digit = 4'd0;
      SEG_1:     digit = 4'd1;
      SEG_2:     digit = 4'd2;
      SEG_3:     digit = 4'd3;
      SEG_4:     digit = 4'd4;
      SEG_5:     digit = 4'd5;
      SEG_6:     digit = 4'd6;
      SEG_7:     digit = 4'd7;
      SEG_8:     digit = 4'd8;
      SEG_9:     digit = 4'd9;
`ifdef SEG_BLANK_AS_ZERO_EN
      SEG_BLANK: digit = 4'd0;
`endif
      default:   legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg_scan_decoder.sv
// Rebuilds the 8-digit BCD value from a scanned AN/CAT display; capture 1+SETTLE_CYCLES cycles after a pin change.
// Free-running receiver with no backpressure; blank-as-zero decode selected by SEG_BLANK_AS_ZERO_EN.
module seg_scan_decoder
  import seg_scan_pkg::*;
#(
  parameter int SETTLE_CYCLES = 16,
  parameter int CNT_W         = 16
) (
  input  logic        clk,
  input  logic        clr,
  input  logic [7:0]  AN,
  input  logic [6:0]  CAT,
  output logic [31:0] bcd_q,
  output logic [7:0]  digit_valid,
  output logic        frame_done,
  output logic        seg_err,
  output logic        an_err
);

  localparam logic [CNT_W-1:0] SETTLE_VAL = CNT_W'(SETTLE_CYCLES);

  logic [7:0]       r_an;
  logic [7:0]       r_an_prev;
  logic [6:0]       r_cat;
  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [7:0]       r_seen;
  logic [31:0]      r_bcd;
  logic [7:0]       r_valid;
  logic             r_frame_done;
  logic             r_seg_err;
  logic             r_an_err;

  logic [7:0]       w_an_low;
  logic             w_onehot;
  logic             w_multi;
  logic             w_changed;
  logic [2:0]       w_idx;
  logic [3:0]       w_digit;
  logic             w_legal;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_capture;
  logic [7:0]       w_seen_cap;
  logic             w_frame;

  assign w_an_low  = ~r_an;
  assign w_onehot  = $onehot(w_an_low);
  assign w_multi   = (w_an_low != '0) && !w_onehot;
  assign w_changed = (r_an != r_an_prev);

  always_comb begin
    w_idx = 3'd0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (w_an_low[i]) w_idx = 3'(i);
    end
  end

  seg7_to_bcd u_seg7 (
    .cat   (r_cat),
    .digit (w_digit),
    .legal (w_legal)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_capture   = 1'b0;
    case (r_state)
      WAIT: begin
        if (w_onehot) begin
          w_state_nxt = SETTLE;
          w_cnt_nxt   = CNT_W'(1);
        end
      end
      SETTLE: begin
        if (!w_changed) begin
          w_cnt_nxt = r_cnt + 1'b1;
        end else if (w_onehot) begin
          w_cnt_nxt = CNT_W'(1);
        end else begin
          w_state_nxt = WAIT;
          w_cnt_nxt   = '0;
        end
      end
      HOLD: begin
        if (w_changed) begin
          w_state_nxt = w_onehot ? SETTLE : WAIT;
          w_cnt_nxt   = w_onehot ? CNT_W'(1) : '0;
        end
      end
      default: begin
        w_state_nxt = WAIT;
        w_cnt_nxt   = '0;
      end
    endcase
    // Reaching the settle count captures in the same cycle, so SETTLE_CYCLES=1 captures on first sight
    if (w_state_nxt == SETTLE && w_cnt_nxt == SETTLE_VAL) begin
      w_capture   = 1'b1;
      w_state_nxt = HOLD;
    end
  end

  assign w_seen_cap = r_seen | w_an_low;
  assign w_frame    = w_capture && (w_seen_cap == 8'hFF);

  always_ff @(posedge clk) begin
    if (clr) begin
      r_an         <= 8'hFF;
      r_an_prev    <= 8'hFF;
      r_cat        <= SEG_BLANK;
      r_state      <= WAIT;
      r_cnt        <= '0;
      r_seen       <= '0;
      r_bcd        <= '0;
      r_valid      <= '0;
      r_frame_done <= 1'b0;
      r_seg_err    <= 1'b0;
      r_an_err     <= 1'b0;
    end else begin
      r_an         <= AN;
      r_an_prev    <= r_an;
      r_cat        <= CAT;
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_frame_done <= w_frame;
      if (w_multi) r_an_err <= 1'b1;
      if (w_capture) begin
        // Completing capture opens the next frame immediately
        r_seen <= w_frame ? 8'h00 : w_seen_cap;
        if (w_legal) begin
          r_bcd[{w_idx, 2'b00} +: 4] <= w_digit;
          r_valid[w_idx]             <= 1'b1;
        end else begin
          r_valid[w_idx] <= 1'b0;
          r_seg_err      <= 1'b1;
        end
      end
    end
  end

  assign bcd_q       = r_bcd;
  assign digit_valid = r_valid;
  assign frame_done  = r_frame_done;
  assign seg_err     = r_seg_err;
  assign an_err      = r_an_err;

endmodule
